bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the serial sequence-detector FSM.

---
 rtl/bit_serializer_if.sv | 24 ++
 rtl/bit_serializer.sv | 117 +++++++++++
 tb/tb_bit_serializer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle for bit_serializer.
// The master drives words and pause; the slave (serializer) returns ready and the serial stream.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             pause;
    logic             out_bit;
    logic             out_valid;
    logic             out_first;
    logic             out_last;

    modport master (
        output in_data, in_valid, pause,
        input  in_ready, out_bit, out_valid, out_first, out_last
    );

    modport slave (
        input  in_data, in_valid, pause,
        output in_ready, out_bit, out_valid, out_first, out_last
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// A one-word holding buffer lets back-to-back words stream with no idle gap.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    bit_serializer_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] bf_reg;
    logic             bf_v_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CNT_W-1:0] words_sent_reg;

    logic [WIDTH-1:0] sh_next;
    logic             head_bit;
    logic             act;
    logic             adv;
    logic             acc;
    logic             last_bit;
    logic             need;

    // Shift toward the output end; a zero enters at the far end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_edge
                    assign sh_next[gi] = 1'b0;
                end else begin : g_mid
                    assign sh_next[gi] = sh_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_edge
                    assign sh_next[gi] = 1'b0;
                end else begin : g_mid
                    assign sh_next[gi] = sh_reg[gi+1];
                end
            end
        end
        if (MSB_FIRST != 0) begin : g_head_msb
            assign head_bit = sh_reg[WIDTH-1];
        end else begin : g_head_lsb
            assign head_bit = sh_reg[0];
        end
    endgenerate

    assign act      = (state_reg == SHIFT);
    assign adv      = act & ~bus.pause;
    assign acc      = bus.in_valid & ~bf_v_reg;
    assign last_bit = adv & (cnt_reg == LAST_IDX);
    // Shifter becomes free after this edge, so the next word can load directly.
    assign need     = ~act | last_bit;

    assign bus.in_ready  = ~bf_v_reg;
    assign bus.out_valid = adv;
    assign bus.out_bit   = adv ? head_bit : IDLE_BIT;
    assign bus.out_first = adv & (cnt_reg == '0);
    assign bus.out_last  = last_bit;
    assign busy          = act | bf_v_reg;
    assign words_sent    = words_sent_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            sh_reg         <= '0;
            bf_reg         <= '0;
            bf_v_reg       <= 1'b0;
            cnt_reg        <= '0;
            words_sent_reg <= '0;
        end else begin
            if (adv && (cnt_reg != LAST_IDX)) begin
                sh_reg  <= sh_next;
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (need) begin
                if (bf_v_reg) begin
                    sh_reg    <= bf_reg;
                    cnt_reg   <= '0;
                    state_reg <= SHIFT;
                    bf_v_reg  <= 1'b0;
                end else if (acc) begin
                    sh_reg    <= bus.in_data;
                    cnt_reg   <= '0;
                    state_reg <= SHIFT;
                end else begin
                    state_reg <= IDLE;
                end
            end

            if (acc && !need) begin
                bf_reg   <= bus.in_data;
                bf_v_reg <= 1'b1;
            end

            if (last_bit) begin
                words_sent_reg <= words_sent_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance (dut0) and LSB-first, 2-bit-counter instance (dut1).
module tb_bit_serializer;
    logic        clk;
    logic        rst;
    logic        busy0;
    logic        busy1;
    logic [15:0] words_sent0;
    logic [1:0]  words_sent1;
    int          vectors;
    int          miscompares;
    int          valid_seen;
    int          k;

    bit_serializer_if #(.WIDTH(8)) bus0 ();
    bit_serializer_if #(.WIDTH(8)) bus1 ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(16)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus0),
        .busy       (busy0),
        .words_sent (words_sent0)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0), .CNT_W(2)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1),
        .busy       (busy1),
        .words_sent (words_sent1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        settle();
        tick();
        tick();
        rst = 1'b1;
        settle();
    endtask

    // Send one word to dut0 (d1=0, MSB first) or dut1 (d1=1, LSB first) and check its 8 bits.
    task automatic send_word(input bit d1, input logic [7:0] w, input string tag);
        logic ob, ov, of, ol;
        if (d1) begin bus1.in_valid = 1'b1; bus1.in_data = w; end
        else    begin bus0.in_valid = 1'b1; bus0.in_data = w; end
        settle();
        chk1({tag, "_ready"}, d1 ? bus1.in_ready : bus0.in_ready, 1'b1);
        tick();
        if (d1) begin bus1.in_valid = 1'b0; bus1.in_data = 8'h5A; end
        else    begin bus0.in_valid = 1'b0; bus0.in_data = 8'h5A; end
        settle();
        for (int i = 0; i < 8; i++) begin
            ov = d1 ? bus1.out_valid : bus0.out_valid;
            ob = d1 ? bus1.out_bit   : bus0.out_bit;
            of = d1 ? bus1.out_first : bus0.out_first;
            ol = d1 ? bus1.out_last  : bus0.out_last;
            chk1($sformatf("%s_valid%0d", tag, i), ov, 1'b1);
            chk1($sformatf("%s_bit%0d", tag, i), ob, d1 ? w[i] : w[7-i]);
            chk1($sformatf("%s_first%0d", tag, i), of, i == 0);
            chk1($sformatf("%s_last%0d", tag, i), ol, i == 7);
            tick();
            settle();
        end
        chk1({tag, "_end_valid"}, d1 ? bus1.out_valid : bus0.out_valid, 1'b0);
        chk1({tag, "_end_bit"}, d1 ? bus1.out_bit : bus0.out_bit, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = 8'h00; bus0.pause = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.pause = 1'b0;

        // T1: reset asserted with in_valid high, checked before and after clock edges
        #3;
        rst = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'hB4;
        #1;
        chk1("t1_async_valid", bus0.out_valid, 1'b0);
        chk1("t1_async_ready", bus0.in_ready, 1'b1);
        tick();
        tick();
        chk1("t1_valid", bus0.out_valid, 1'b0);
        chk1("t1_bit", bus0.out_bit, 1'b0);
        chk1("t1_ready", bus0.in_ready, 1'b1);
        chk1("t1_busy", busy0, 1'b0);
        chkw("t1_words", words_sent0, 16'd0);
        bus0.in_valid = 1'b0;
        rst = 1'b1;
        settle();

        // T2: single word B4, MSB first
        send_word(1'b0, 8'hB4, "t2");
        chkw("t2_words", words_sent0, 16'd1);
        chk1("t2_busy", busy0, 1'b0);

        // T3: FF then 00 streamed through the holding buffer
        do_reset();
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'hFF;
        settle();
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) bus0.in_data = 8'h00;
            if (i == 1) bus0.in_valid = 1'b0;
            settle();
            chk1($sformatf("t3_valid%0d", i), bus0.out_valid, 1'b1);
            chk1($sformatf("t3_bit%0d", i), bus0.out_bit, i < 8);
            chk1($sformatf("t3_first%0d", i), bus0.out_first, (i % 8) == 0);
            chk1($sformatf("t3_last%0d", i), bus0.out_last, (i % 8) == 7);
            chk1($sformatf("t3_ready%0d", i), bus0.in_ready, (i == 0) || (i >= 8));
            tick();
        end
        settle();
        chk1("t3_end_valid", bus0.out_valid, 1'b0);
        chkw("t3_words", words_sent0, 16'd2);

        // T4: A5 with a 3-cycle pause after the third bit
        do_reset();
        w = 8'hA5;
        bus0.in_valid = 1'b1;
        bus0.in_data  = w;
        settle();
        tick();
        bus0.in_valid = 1'b0;
        valid_seen = 0;
        k = 0;
        for (int c = 0; c < 11; c++) begin
            bus0.pause = (c >= 3) && (c <= 5);
            settle();
            if (bus0.out_valid === 1'b1) valid_seen++;
            if (bus0.pause) begin
                chk1($sformatf("t4_pvalid%0d", c), bus0.out_valid, 1'b0);
                chk1($sformatf("t4_pbit%0d", c), bus0.out_bit, 1'b0);
            end else begin
                chk1($sformatf("t4_valid%0d", c), bus0.out_valid, 1'b1);
                chk1($sformatf("t4_bit%0d", c), bus0.out_bit, w[7-k]);
                chk1($sformatf("t4_first%0d", c), bus0.out_first, k == 0);
                chk1($sformatf("t4_last%0d", c), bus0.out_last, k == 7);
                k++;
            end
            tick();
        end
        bus0.pause = 1'b0;
        settle();
        chkw("t4_valid_count", 16'(valid_seen), 16'd8);
        chk1("t4_end_valid", bus0.out_valid, 1'b0);
        chkw("t4_words", words_sent0, 16'd1);

        // T5: LSB-first instance, then counter wrap with CNT_W=2
        do_reset();
        send_word(1'b1, 8'h01, "t5a");
        chkw("t5_words1", 16'(words_sent1), 16'd1);
        send_word(1'b1, 8'h80, "t5b");
        send_word(1'b1, 8'h3C, "t5c");
        send_word(1'b1, 8'hC1, "t5d");
        chkw("t5_words4", 16'(words_sent1), 16'd0);
        send_word(1'b1, 8'h7E, "t5e");
        chkw("t5_words5", 16'(words_sent1), 16'd1);

        // T6: reset in the middle of a word with the buffer full
        do_reset();
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'hC3;
        settle();
        tick();
        bus0.in_data = 8'h3C;
        settle();
        tick();
        bus0.in_valid = 1'b0;
        settle();
        chk1("t6_buf_full", bus0.in_ready, 1'b0);
        tick();
        tick();
        chk1("t6_bit4_valid", bus0.out_valid, 1'b1);
        chk1("t6_bit4_bit", bus0.out_bit, 1'b0);
        rst = 1'b0;
        settle();
        chk1("t6_rst_valid", bus0.out_valid, 1'b0);
        chk1("t6_rst_bit", bus0.out_bit, 1'b0);
        chk1("t6_rst_busy", busy0, 1'b0);
        chk1("t6_rst_ready", bus0.in_ready, 1'b1);
        chk1("t6_rst_last", bus0.out_last, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk1("t6_rel_ready", bus0.in_ready, 1'b1);
        chk1("t6_rel_busy", busy0, 1'b0);
        chkw("t6_rel_words", words_sent0, 16'd0);
        for (int i = 0; i < 12; i++) begin
            chk1($sformatf("t6_quiet%0d", i), bus0.out_valid, 1'b0);
            tick();
        end
        chk1("t6_end_busy", busy0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
